spi_cfg_seq: RTL and testbench
==============================

SPI_CFG_SEQ -- requirements
Module: spi_cfg_seq

Interface
REQ-001 Parameter RW_FLAG, default 1, width of the read/write flag field.
REQ-002 Parameter ADDR_WIDTH, default 3, register address width.
REQ-003 Parameter DATA_WIDTH, default 8, register data width.
REQ-004 Parameter CMD_WIDTH, default RW_FLAG+ADDR_WIDTH+DATA_WIDTH, command word width.
REQ-005 Parameter NUM_REGS, default 8, table entries. Legal range 1..2^ADDR_WIDTH.
REQ-006 Parameter INIT_DATA, default all zero, NUM_REGS*DATA_WIDTH bits. Entry i data = INIT_DATA[i*DATA_WIDTH +: DATA_WIDTH]; entry i address = i.
REQ-007 clk  input  1  single system clock, all logic on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  one-cycle request to run the configuration sequence.
REQ-010 busy  output  1  high while the sequence is running.
REQ-011 done  output  1  one-cycle pulse when the sequence ends.
REQ-012 err  output  1  sticky readback or timeout error.
REQ-013 err_addr  output  ADDR_WIDTH  address of the first failing entry.
REQ-014 cmd_valid  output  1  command valid to the downstream SPI master.
REQ-015 cmd_ready  input  1  downstream ready; high only while the master is idle.
REQ-016 cmd_data  output  CMD_WIDTH  command word {rw, addr, data}.
REQ-017 read_valid  input  1  one-cycle read-data strobe from the master.
REQ-018 read_data  input  DATA_WIDTH  read data from the master.

Function
REQ-019 The block SHALL use a registered FSM with states IDLE, WR_REQ, WR_DRAIN, RD_REQ, RD_WAIT and DONE.
REQ-020 In IDLE, a sampled start SHALL clear err and err_addr, zero the entry index, and go to WR_REQ, so cmd_valid is high on the next cycle.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 In WR_REQ, cmd_data SHALL equal {1'b1, idx, INIT_DATA entry idx}.
REQ-023 cmd_valid and cmd_data SHALL stay stable until cmd_valid && cmd_ready.
REQ-024 On a write handshake with idx < NUM_REGS-1, idx SHALL increment and the FSM SHALL stay in WR_REQ.
REQ-025 On the last write handshake, the FSM SHALL go to WR_DRAIN.
REQ-026 WR_DRAIN SHALL deassert cmd_valid and wait for cmd_ready=1, no earlier than the second cycle after the handshake, so the last frame has completed.
REQ-027 When WR_DRAIN exits, it SHALL go to RD_REQ with idx=0 if readback is enabled, else to DONE.
REQ-028 In RD_REQ, cmd_data SHALL equal {1'b0, idx, zero data}.
REQ-029 After a read handshake the FSM SHALL go to RD_WAIT; exactly one read is outstanding at any time.
REQ-030 RD_WAIT compare: on read_valid, if read_data differs from INIT_DATA entry idx and err=0, err SHALL set and err_addr SHALL take idx.
REQ-031 RD_WAIT advance: on read_valid, the FSM SHALL go to RD_REQ with idx+1, or to DONE after entry NUM_REGS-1.
REQ-032 A mismatch SHALL NOT abort the sequence; err_addr SHALL hold the first mismatch only.
REQ-033 A 10-bit timeout counter SHALL run in RD_WAIT. At count 1023 without read_valid it SHALL set err, load err_addr with idx (if err was 0), and go to DONE.
REQ-034 read_valid outside RD_WAIT SHALL be ignored.
REQ-035 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-036 busy SHALL be 1 in every state except IDLE.
REQ-037 cmd_valid SHALL be 1 only in WR_REQ and RD_REQ.
REQ-038 err and err_addr SHALL hold their values after DONE until the next accepted start.

Reset
REQ-039 On rst_n low, the FSM SHALL be IDLE, and idx, the timeout counter, cmd_valid, busy, done, err and err_addr SHALL all be 0.
REQ-040 cmd_data SHALL be 0 in IDLE.
REQ-041 Reset asserted mid-sequence SHALL abort immediately with no further commands issued.

Configuration
REQ-042 Macro SPI_CFG_READBACK_EN, when defined, SHALL compile in the RD_REQ/RD_WAIT path, the comparison and the timeout logic.
REQ-043 When SPI_CFG_READBACK_EN is undefined, WR_DRAIN SHALL go straight to DONE, err and err_addr SHALL be tied 0, and read_valid/read_data SHALL be unused.

Verification
REQ-044 Write sequence (NUM_REGS=4, INIT_DATA=32'hA53C0F81, start pulse) -> cmd_data accepted in order 12'h881, 12'h90F, 12'hA3C, 12'hBA5.
REQ-045 Readback pass (macro defined, master model echoes writes) -> reads 12'h000, 12'h100, 12'h200, 12'h300 issued, then done pulses with err=0.
REQ-046 Readback mismatch (model returns 8'h00 for address 2 and address 3) -> err=1, err_addr=2, all four reads still issued, done pulses once.
REQ-047 Timeout (model never asserts read_valid for address 1) -> err=1, err_addr=1, done pulse 1024 cycles after entering RD_WAIT, no read of address 2.
REQ-048 Ignored start and reset (start re-pulsed while busy, then rst_n low during the third write) -> no restart; after reset cmd_valid=0, busy=0, FSM in IDLE.
REQ-049 Back-pressure (cmd_ready held low 50 cycles during WR_REQ) -> cmd_valid=1 and cmd_data constant for all 50 cycles.

Source files
------------

// File: rtl/spi_cfg_seq.sv
// ---------------------------------------------------------------------------
// spi_cfg_seq
//   Power-on configuration sequencer for a register-mapped SPI device.
//   On a start pulse it streams every entry of a constant register table to a
//   downstream SPI master as write commands {rw=1, addr, data}, waits for the
//   final frame to drain, and then (optionally) reads every register back and
//   compares it with the table, flagging the first failing address.
//
//   Optional feature macro: SPI_CFG_READBACK_EN
//     defined   -> readback path (RD_REQ/RD_WAIT), compare and 10-bit timeout
//     undefined -> write-only sequencer; err/err_addr tied low and
//                  read_valid/read_data are unused
// ---------------------------------------------------------------------------
module spi_cfg_seq #(
  parameter int RW_FLAG    = 1,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = RW_FLAG + ADDR_WIDTH + DATA_WIDTH,
  parameter int NUM_REGS   = 8,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] INIT_DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [CMD_WIDTH-1:0]  cmd_data,
  input  logic                  read_valid,
  input  logic [DATA_WIDTH-1:0] read_data
);

  // Sequencer states; the read states are only reachable with readback built in.
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_DRAIN,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

  localparam int TBL_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   idx_inc;
  logic                    drain_hold;

  // NOTE: the register table is a constant decoded from INIT_DATA, not storage,
  // so it needs no reset; it is padded with zeros up to the full address space
  // so any idx value indexes a defined entry.
  logic [DATA_WIDTH-1:0]   init_tbl [TBL_DEPTH];

  for (genvar g = 0; g < TBL_DEPTH; g++) begin : g_tbl
    if (g < NUM_REGS) begin : g_used
      assign init_tbl[g] = INIT_DATA[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign init_tbl[g] = '0;
    end
  end

  assign idx_inc = idx + ADDR_WIDTH'(1);

  // Pack one command word as {rw, addr, data}.
  function automatic logic [CMD_WIDTH-1:0] make_cmd(
    input logic                  rw,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] data
  );
    return CMD_WIDTH'({RW_FLAG'(rw), addr, data});
  endfunction

`ifdef SPI_CFG_READBACK_EN
  localparam int TMO_WIDTH = 10;
  logic [TMO_WIDTH-1:0] tmo_cnt;
`else
  // Write-only build: no readback, so no error can ever be raised.
  assign err      = 1'b0;
  assign err_addr = '0;

  logic unused_rd;
  assign unused_rd = ^{read_valid, read_data};
`endif

  // Sequencer FSM: walks the table, drives the command port and all flags.
  // NOTE: every register here uses non-blocking assignment so that all
  // next-state decisions read the values from the start of the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      drain_hold <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SPI_CFG_READBACK_EN
      tmo_cnt    <= '0;
      err        <= 1'b0;
      err_addr   <= '0;
`endif
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            // Accepted start: clear the previous run's error and launch entry 0.
            state     <= WR_REQ;
            idx       <= '0;
            busy      <= 1'b1;
            cmd_valid <= 1'b1;
            cmd_data  <= make_cmd(1'b1, '0, init_tbl[0]);
`ifdef SPI_CFG_READBACK_EN
            err       <= 1'b0;
            err_addr  <= '0;
`endif
          end
        end

        WR_REQ: begin
          // cmd_valid is high throughout this state, so ready alone is the handshake.
          if (cmd_ready) begin
            if (idx == LAST_IDX) begin
              state      <= WR_DRAIN;
              cmd_valid  <= 1'b0;
              cmd_data   <= '0;
              drain_hold <= 1'b1;
            end else begin
              idx      <= idx_inc;
              cmd_data <= make_cmd(1'b1, idx_inc, init_tbl[idx_inc]);
            end
          end
        end

        WR_DRAIN: begin
          // The first cycle after the last handshake may still show the
          // master's stale ready, so ready only counts from the second cycle.
          if (drain_hold) begin
            drain_hold <= 1'b0;
          end else if (cmd_ready) begin
`ifdef SPI_CFG_READBACK_EN
            state     <= RD_REQ;
            idx       <= '0;
            cmd_valid <= 1'b1;
            cmd_data  <= make_cmd(1'b0, '0, '0);
`else
            state     <= DONE;
            done      <= 1'b1;
`endif
          end
        end

`ifdef SPI_CFG_READBACK_EN
        RD_REQ: begin
          if (cmd_ready) begin
            state     <= RD_WAIT;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            tmo_cnt   <= '0;
          end
        end

        RD_WAIT: begin
          if (read_valid) begin
            // Only the first mismatch is recorded; the sequence keeps going.
            if ((read_data != init_tbl[idx]) && !err) begin
              err      <= 1'b1;
              err_addr <= idx;
            end
            if (idx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= RD_REQ;
              idx       <= idx_inc;
              cmd_valid <= 1'b1;
              cmd_data  <= make_cmd(1'b0, idx_inc, '0);
            end
          end else if (tmo_cnt == '1) begin
            // Read never came back: give up on the rest of the table.
            if (!err) begin
              err      <= 1'b1;
              err_addr <= idx;
            end
            state <= DONE;
            done  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
          end
        end
`endif

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
          cmd_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_spi_cfg_seq
//   Self-checking bench for spi_cfg_seq (NUM_REGS=4, INIT_DATA=32'hA53C0F81).
//   A behavioural SPI master answers commands with random latency and echoes
//   written data on reads (optionally corrupted or withheld). A reference model
//   builds the expected command list and error outcome from the table rules.
//   Readback-only scenarios are compiled when SPI_CFG_READBACK_EN is defined.
// ---------------------------------------------------------------------------
module tb_spi_cfg_seq;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int CW = 1 + AW + DW;
  localparam logic [NR*DW-1:0] INIT = 32'hA53C0F81;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err, cmd_valid;
  logic [AW-1:0] err_addr;
  logic [CW-1:0] cmd_data;
  logic          cmd_ready = 1'b1;
  logic          read_valid = 1'b0;
  logic [DW-1:0] read_data = '0;

  int total = 0;
  int bad   = 0;

  // Table contents restated byte by byte (entry 0 first).
  logic [7:0] init_b [NR] = '{8'h81, 8'h0F, 8'h3C, 8'hA5};

  // Master-model controls.
  int          lat_min  = 1;
  int          lat_max  = 4;
  bit          hold_low = 1'b0;
  bit          stray_en = 1'b0;
  int          tmo_addr = -1;
  logic [NR-1:0] corrupt = '0;

  // Master-model state.
  logic [DW-1:0] mem [8];
  bit            hs_prev  = 1'b0;
  logic [CW-1:0] cmd_prev = '0;
  int            busy_cnt = 0;
  bit            rd_pend  = 1'b0;
  int            rd_addr  = 0;

  logic [CW-1:0] got_q [$];
  int            got_cyc [$];
  logic [CW-1:0] exp_q [$];
  logic          exp_err;
  logic [AW-1:0] exp_eaddr;

  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  always #5 clk = ~clk;

  spi_cfg_seq #(
    .RW_FLAG    (1),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CMD_WIDTH  (CW),
    .NUM_REGS   (NR),
    .INIT_DATA  (INIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .read_valid (read_valid),
    .read_data  (read_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Behavioural SPI master: one frame at a time, ready only while idle.
  initial forever begin
    @(posedge clk);
    #1;
    read_valid = 1'b0;
    if (!rst_n) begin
      hs_prev   = 1'b0;
      busy_cnt  = 0;
      rd_pend   = 1'b0;
      cmd_ready = 1'b1;
    end else begin
      if (hs_prev) begin
        got_q.push_back(cmd_prev);
        got_cyc.push_back(cyc);
        busy_cnt = $urandom_range(lat_max, lat_min);
        if (cmd_prev[CW-1]) mem[cmd_prev[CW-2 -: AW]] = cmd_prev[DW-1:0];
        else begin
          rd_pend = 1'b1;
          rd_addr = int'(cmd_prev[CW-2 -: AW]);
        end
      end
      if (busy_cnt > 0) begin
        cmd_ready = 1'b0;
        busy_cnt--;
        if (busy_cnt == 0 && rd_pend) begin
          rd_pend = 1'b0;
          if (rd_addr != tmo_addr) begin
            read_valid = 1'b1;
            read_data  = corrupt[rd_addr] ? 8'h00 : mem[rd_addr];
          end
        end
      end else begin
        cmd_ready = !hold_low;
        if (stray_en && $urandom_range(3, 0) == 0) begin
          read_valid = 1'b1;
          read_data  = 8'($urandom);
        end
      end
      hs_prev  = cmd_valid && cmd_ready;
      cmd_prev = cmd_data;
    end
  end

  // Reference model: expected command stream and error result of one run.
  task automatic model();
    exp_q.delete();
    exp_err   = 1'b0;
    exp_eaddr = '0;
    for (int i = 0; i < NR; i++) exp_q.push_back({1'b1, AW'(i), init_b[i]});
`ifdef SPI_CFG_READBACK_EN
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back({1'b0, AW'(i), 8'h00});
      if (!exp_err && (i == tmo_addr || corrupt[i])) begin
        exp_err   = 1'b1;
        exp_eaddr = AW'(i);
      end
      if (i == tmo_addr) break;
    end
`endif
  endtask

  task automatic run_seq(input string nm, input bit restart, input bit bp);
    int d0;
    bit seen;
    bit bp_done;
    int k;
    int good;
    model();
    got_q.delete();
    got_cyc.delete();
    d0 = done_cnt;
    seen = 1'b0;
    bp_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, ":valid_after_start"}, 32'(cmd_valid), 32'd1);
    check({nm, ":busy_after_start"}, 32'(busy), 32'd1);
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else begin
        start = restart && (t == 2 || t == 4);
        if (bp && !bp_done && got_q.size() == 1) begin
          bp_done  = 1'b1;
          hold_low = 1'b1;
          @(negedge clk);
          @(negedge clk);
          k = got_q.size();
          good = 0;
          for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1 && cmd_data === exp_q[k]) good++;
          end
          check({nm, ":bp_stable_cycles"}, 32'(good), 32'd50);
          check({nm, ":bp_no_handshake"}, 32'(got_q.size()), 32'(k));
          hold_low = 1'b0;
        end
      end
    end
    start = 1'b0;
    check({nm, ":done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check({nm, ":done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({nm, ":cmd_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s:cmd%0d", nm, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx,
            32'(exp_q[i]));
    check({nm, ":err"}, 32'(err), 32'(exp_err));
    check({nm, ":err_addr"}, 32'(err_addr), 32'(exp_eaddr));
    check({nm, ":idle_busy"}, 32'(busy), 32'd0);
    check({nm, ":idle_valid"}, 32'(cmd_valid), 32'd0);
    check({nm, ":idle_data"}, 32'(cmd_data), 32'd0);
  endtask

  task automatic reset_mid();
    bit reached;
    model();
    got_q.delete();
    reached = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 500 && !reached; t++) begin
      @(negedge clk);
      if (got_q.size() == 2) reached = 1'b1;
    end
    check("rst:third_write_reached", 32'(reached), 32'd1);
    check("rst:third_write_data", 32'(cmd_data), 32'(exp_q[2]));
    rst_n = 1'b0;
    #1;
    check("rst:valid_low", 32'(cmd_valid), 32'd0);
    check("rst:busy_low", 32'(busy), 32'd0);
    check("rst:done_low", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst:no_more_cmds", 32'(got_q.size()), 32'd2);
    check("rst:stay_idle_busy", 32'(busy), 32'd0);
    check("rst:stay_idle_valid", 32'(cmd_valid), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:err", 32'(err), 32'd0);
    check("reset:err_addr", 32'(err_addr), 32'd0);
    check("reset:cmd_data", 32'(cmd_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean write (and echo readback) with stray read strobes outside RD_WAIT.
    stray_en = 1'b1;
    run_seq("pass", 1'b0, 1'b0);
    stray_en = 1'b0;

    // start re-pulsed while busy must not restart or add a done pulse.
    lat_max = 1;
    run_seq("restart", 1'b1, 1'b0);
    lat_max = 4;

    // Back-pressure during the write phase.
    run_seq("bp", 1'b0, 1'b1);

`ifdef SPI_CFG_READBACK_EN
    corrupt = 4'b1100;
    run_seq("mismatch", 1'b0, 1'b0);
    corrupt = '0;

    tmo_addr = 1;
    run_seq("timeout", 1'b0, 1'b0);
    check("timeout:reads_issued", 32'(got_q.size()), 32'(NR + 2));
    check("timeout:done_latency",
          32'(done_cyc - ((got_cyc.size() > NR + 1) ? got_cyc[NR+1] : 0)), 32'd1024);
    tmo_addr = -1;
`endif

    // Reset during the third write, then a fresh run from IDLE.
    reset_mid();
    run_seq("after_rst", 1'b0, 1'b0);

    // Randomised runs: latencies, corrupted reads, stray strobes.
    for (int r = 0; r < 6; r++) begin
      lat_max  = $urandom_range(6, 1);
      corrupt  = NR'($urandom);
      stray_en = 1'($urandom_range(1, 0));
      run_seq($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
